mem_arbiter: RTL and testbench

Memory-side responder for the pipelined LC-3b datapath's two memory ports: instruction port a (read-only) and data port b (read/write). Serialises both onto one word-wide physical memory interface. Holds each completed response until every outstanding request from the same pipeline step has completed, then asserts all responses in a single cycle, because the pipeline advances only when `mem_resp_a` and `mem_resp_b` are high together.

---
 rtl/lc3b_types.sv | 17 +
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b word type and the memory arbiter state encoding.
`default_nettype none

package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2,
        RESPOND = 2'd3
    } lc3b_arb_state;

endpackage : lc3b_types

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// Pipeline-side ports a/b plus the physical memory port of the arbiter.
`default_nettype none

interface mem_arbiter_if;
    import lc3b_types::*;

    logic       mem_read_a;
    lc3b_word   mem_address_a;
    logic       mem_resp_a;
    lc3b_word   mem_rdata_a;

    logic       mem_read_b;
    logic       mem_write_b;
    logic [1:0] mem_wmask_b;
    lc3b_word   mem_address_b;
    lc3b_word   mem_wdata_b;
    logic       mem_resp_b;
    lc3b_word   mem_rdata_b;

    logic       pmem_read;
    logic       pmem_write;
    lc3b_word   pmem_address;
    lc3b_word   pmem_wdata;
    logic [1:0] pmem_wmask;
    logic       pmem_resp;
    lc3b_word   pmem_rdata;

    modport slave (
        input  mem_read_a, mem_address_a,
        output mem_resp_a, mem_rdata_a,
        input  mem_read_b, mem_write_b, mem_wmask_b, mem_address_b, mem_wdata_b,
        output mem_resp_b, mem_rdata_b,
        output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask,
        input  pmem_resp, pmem_rdata
    );

    modport master (
        output mem_read_a, mem_address_a,
        input  mem_resp_a, mem_rdata_a,
        output mem_read_b, mem_write_b, mem_wmask_b, mem_address_b, mem_wdata_b,
        input  mem_resp_b, mem_rdata_b,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask,
        output pmem_resp, pmem_rdata
    );

endinterface : mem_arbiter_if

`default_nettype wire

// File: rtl/mem_arbiter.sv
// Serialises instruction port a and data port b onto one physical memory
// port and releases both responses together in a single RESPOND cycle.
`default_nettype none

module mem_arbiter
    import lc3b_types::*;
#(
    parameter int B_FIRST = 1
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    mem_arbiter_if.slave bus
);

    lc3b_arb_state state, next_state;
    logic          done_a, done_b;
    lc3b_word      rdata_a_q, rdata_b_q;

    logic need_a, need_b, pend_a, pend_b;

    assign need_a = bus.mem_read_a;
    assign need_b = bus.mem_read_b | bus.mem_write_b;
    assign pend_a = need_a & ~done_a;
    assign pend_b = need_b & ~done_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            done_a    <= 1'b0;
            done_b    <= 1'b0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            state <= next_state;
            unique case (state)
                SERVE_A: begin
                    if (bus.pmem_resp) begin
                        rdata_a_q <= bus.pmem_rdata;
                        done_a    <= 1'b1;
                    end
                end
                SERVE_B: begin
                    if (bus.pmem_resp) begin
                        if (bus.mem_read_b) begin
                            rdata_b_q <= bus.pmem_rdata;
                        end
                        done_b <= 1'b1;
                    end
                end
                RESPOND: begin
                    done_a <= 1'b0;
                    done_b <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state       = state;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        bus.pmem_wmask   = 2'b00;
        bus.mem_resp_a   = 1'b0;
        bus.mem_resp_b   = 1'b0;
        bus.mem_rdata_a  = rdata_a_q;
        bus.mem_rdata_b  = rdata_b_q;

        unique case (state)
            IDLE: begin
                if (pend_a && pend_b) begin
                    next_state = (B_FIRST != 0) ? SERVE_B : SERVE_A;
                end else if (pend_a) begin
                    next_state = SERVE_A;
                end else if (pend_b) begin
                    next_state = SERVE_B;
                end else if (need_a || need_b) begin
                    next_state = RESPOND;
                end
            end
            SERVE_A: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = bus.mem_address_a;
                bus.pmem_wmask   = 2'b11;
                if (bus.pmem_resp) begin
                    next_state = pend_b ? SERVE_B : RESPOND;
                end
            end
            SERVE_B: begin
                bus.pmem_read    = bus.mem_read_b;
                bus.pmem_write   = bus.mem_write_b;
                bus.pmem_address = bus.mem_address_b;
                bus.pmem_wdata   = bus.mem_wdata_b;
                bus.pmem_wmask   = bus.mem_wmask_b;
                if (bus.pmem_resp) begin
                    next_state = pend_a ? SERVE_A : RESPOND;
                end
            end
            RESPOND: begin
                // A port withdrawn mid-service still has done set; need gates it off.
                bus.mem_resp_a = done_a & need_a;
                bus.mem_resp_b = done_b & need_b;
                next_state     = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a fixed-latency physical memory model.
`default_nettype none

module tb_mem_arbiter;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.B_FIRST(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic     ra, rb, rd_a, rd_b;
        lc3b_word da, db;
        int       cyc;
    } exp_t;

    typedef struct {
        lc3b_word   addr, wdata;
        logic [1:0] wmask;
        logic       rd, wr;
    } phys_t;

    exp_t  exp_q[$];
    phys_t plog[$];
    int    nvec = 0, nmis = 0;
    int    cyc = 0;
    int    lat = 2;
    int    rd_cycles = 0;
    int    start = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic lc3b_word mem_val(input lc3b_word a);
        case (a)
            16'h0010: return 16'h1234;
            16'h0020: return 16'hAAAA;
            16'h0100: return 16'h5555;
            default:  return a ^ 16'hC3C3;
        endcase
    endfunction

    // Physical memory: a transaction completes lat cycles after it starts.
    bit busy = 0;
    int cnt = 0;
    always @(negedge clk) begin
        bus.pmem_resp = 1'b0;
        if (!rst_n) begin
            busy = 0;
            cnt  = 0;
        end else begin
            if (bus.pmem_read) rd_cycles++;
            if (!busy && (bus.pmem_read || bus.pmem_write)) begin
                busy = 1;
                cnt  = 0;
            end
            if (busy) begin
                cnt++;
                if (cnt == lat) begin
                    bus.pmem_resp  = 1'b1;
                    bus.pmem_rdata = mem_val(bus.pmem_address);
                    plog.push_back('{bus.pmem_address, bus.pmem_wdata, bus.pmem_wmask,
                                     bus.pmem_read, bus.pmem_write});
                    busy = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (bus.mem_resp_a || bus.mem_resp_b)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", {bus.mem_resp_a, bus.mem_resp_b}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_a", bus.mem_resp_a, e.ra);
                chk("resp_b", bus.mem_resp_b, e.rb);
                if (e.ra && e.rd_a) chk("rdata_a", bus.mem_rdata_a, e.da);
                if (e.rb && e.rd_b) chk("rdata_b", bus.mem_rdata_b, e.db);
                chk("resp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic idle_bus();
        bus.mem_read_a    = 0;
        bus.mem_address_a = '0;
        bus.mem_read_b    = 0;
        bus.mem_write_b   = 0;
        bus.mem_wmask_b   = 2'b00;
        bus.mem_address_b = '0;
        bus.mem_wdata_b   = '0;
    endtask

    task automatic drive(input logic ra, input lc3b_word aa, input logic rb, input logic wb,
                         input logic [1:0] m, input lc3b_word ab, input lc3b_word wd);
        bus.mem_read_a    = ra;
        bus.mem_address_a = aa;
        bus.mem_read_b    = rb;
        bus.mem_write_b   = wb;
        bus.mem_wmask_b   = m;
        bus.mem_address_b = ab;
        bus.mem_wdata_b   = wd;
        start = cyc;
    endtask

    task automatic begin_case(input int l);
        @(posedge clk); #1;
        lat = l;
        rd_cycles = 0;
        plog.delete();
    endtask

    task automatic wait_resp(input int max);
        int t = 0;
        bit seen = 0;
        while (!seen && t < max) begin
            @(negedge clk);
            t++;
            if (bus.mem_resp_a || bus.mem_resp_b) seen = 1;
        end
        if (!seen) begin
            chk("resp_timeout", 0, 1);
            exp_q.delete();
        end
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_bus();
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp", {bus.mem_resp_a, bus.mem_resp_b}, 0);
        chk("rst_rdata", {bus.mem_rdata_a, bus.mem_rdata_b}, 0);
        chk("rst_pmem", {bus.pmem_read, bus.pmem_write, bus.pmem_wmask,
                         bus.pmem_address, bus.pmem_wdata}, 0);
        rst_n = 1'b1;

        // Port a alone, L=3: response in cycle 5
        begin_case(3);
        drive(1, 16'h0010, 0, 0, 2'b00, 16'h0, 16'h0);
        exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0, start + 4});
        wait_resp(20);
        chk("a_rd_cycles", rd_cycles, 3);
        chk("a_paddr", plog.size() > 0 ? plog[0].addr : 16'hXXXX, 16'h0010);
        chk("a_rdata_hold", bus.mem_rdata_a, 16'h1234);

        // Both ports, b first, L=2: joint response in cycle 6
        begin_case(2);
        drive(1, 16'h0020, 1, 0, 2'b11, 16'h0100, 16'h0);
        exp_q.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 16'hAAAA, 16'h5555, start + 5});
        wait_resp(20);
        chk("both_nphys", plog.size(), 2);
        if (plog.size() == 2) begin
            chk("both_paddr0", plog[0].addr, 16'h0100);
            chk("both_paddr1", plog[1].addr, 16'h0020);
        end

        // Port b write
        begin_case(2);
        drive(0, 16'h0, 0, 1, 2'b01, 16'h0200, 16'hBEEF);
        exp_q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, start + 3});
        wait_resp(20);
        chk("wr_nphys", plog.size(), 1);
        if (plog.size() == 1) begin
            chk("wr_fields", {plog[0].wr, plog[0].rd, plog[0].wmask, plog[0].addr, plog[0].wdata},
                {1'b1, 1'b0, 2'b01, 16'h0200, 16'hBEEF});
        end
        chk("wr_rd_cycles", rd_cycles, 0);

        // Late arrival of b during SERVE_A: straight into SERVE_B
        begin_case(2);
        drive(1, 16'h0030, 0, 0, 2'b00, 16'h0, 16'h0);
        exp_q.push_back('{1'b1, 1'b1, 1'b1, 1'b1, mem_val(16'h0030), mem_val(16'h0400), start + 5});
        @(posedge clk); #1;
        bus.mem_read_b    = 1;
        bus.mem_address_b = 16'h0400;
        wait_resp(20);
        chk("late_rd_cycles", rd_cycles, 4);
        if (plog.size() == 2) chk("late_paddr1", plog[1].addr, 16'h0400);
        else chk("late_nphys", plog.size(), 2);

        // b withdrawn during SERVE_B: a still answered, b suppressed
        begin_case(2);
        drive(1, 16'h0040, 1, 0, 2'b11, 16'h0300, 16'h0);
        exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, mem_val(16'h0040), 16'h0, start + 5});
        repeat (2) begin @(posedge clk); #1; end
        bus.mem_read_b = 0;
        wait_resp(20);
        chk("wd_nphys", plog.size(), 2);
        if (plog.size() == 2) chk("wd_paddr0", plog[0].addr, 16'h0300);

        // Reset in the middle of SERVE_B
        begin_case(3);
        drive(0, 16'h0, 1, 0, 2'b11, 16'h0500, 16'h0);
        @(posedge clk); #1;
        chk("rst_mid_busy", bus.pmem_read, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_pmem", {bus.pmem_read, bus.pmem_write, bus.pmem_address}, 0);
        chk("rst_mid_resp", {bus.mem_resp_a, bus.mem_resp_b}, 0);
        idle_bus();
        @(posedge clk); #1;
        rst_n = 1'b1;

        begin_case(3);
        drive(1, 16'h0010, 0, 0, 2'b00, 16'h0, 16'h0);
        exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0, start + 4});
        wait_resp(20);
        chk("post_rst_rd_cycles", rd_cycles, 3);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule : tb_mem_arbiter

`default_nettype wire
